axis_spi_adc_ctrl: RTL and testbench

Parametrised second-generation SPI ADC front end. It generates SCK from a programmable divider instead of a gated clock buffer, which frees it from the aclk rate. It runs triggered multi-lane conversions and performs register accesses with readback on a dedicated AXI-Stream output. It sits between the acquisition trigger logic and the capture DMA / PS register path.

---
 rtl/axis_spi_adc_ctrl_if.sv | 16 +
 rtl/axis_spi_adc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_axis_spi_adc_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_spi_adc_ctrl_if.sv
// AXI-Stream channel bundle used by axis_spi_adc_ctrl.
//   tdata  : payload, DATA_WIDTH bits
//   tvalid : source has a beat
//   tready : sink accepts the beat
// master drives tdata/tvalid; slave drives tready.
`timescale 1ns/1ps
interface axis_spi_adc_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_adc_ctrl.sv
// SPI ADC front end with a divided SCK, triggered multi-lane conversions and
// register accesses with readback.
// Ports:
//   aclk, areset           clock; asynchronous active-high reset
//   trigger                conversion request, rising-edge sensitive
//   spi_sdi[NUM_SDI]       ADC data lanes; spi_sdo/csn/sck/resetn SPI outputs
//   s_axis                 command words: [31] stay, [23:0] register frame
//   m_axis                 conversion words (zero-extended)
//   m_axis_reg             register readback (bits from spi_sdi[0])
//   overrun                sticky: trigger that could not start a frame
//   drop_count             saturating count of conversions lost to backpressure
`timescale 1ns/1ps
module axis_spi_adc_ctrl #(
  parameter int NUM_SDI    = 4,
  parameter int CNV_BITS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SCK_DIV    = 2,
  parameter int CNV_WAIT   = 8,
  parameter int REG_BITS   = 24
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 trigger,
  input  logic [NUM_SDI-1:0]   spi_sdi,
  output logic                 spi_sdo,
  output logic                 spi_csn,
  output logic                 spi_sck,
  output logic                 spi_resetn,
  axis_spi_adc_ctrl_if.slave   s_axis,
  axis_spi_adc_ctrl_if.master  m_axis,
  axis_spi_adc_ctrl_if.master  m_axis_reg,
  output logic                 overrun,
  output logic [7:0]           drop_count
);

  localparam int CNV_N = CNV_BITS / NUM_SDI;
  localparam int DW    = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_GAP} state_t;
  typedef enum logic {MODE_CNV, MODE_REG} mode_t;

  state_t          state, state_n;
  mode_t           mode;
  logic            stay;
  logic            trig_q, trig_edge;
  logic [15:0]     wait_cnt, div_cnt, half_cnt;
  logic            sck_r, csn_r, sdo_r;
  logic [23:0]     sdo_sr;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   m_tdata, r_tdata;
  logic            m_tvalid, r_tvalid;
  logic            overrun_r;
  logic [7:0]      drop_r;

  logic            s_tready_w, cmd_acc, tick, shift_end, enter_shift;
  logic [15:0]     half_last;
  logic            unused_cmd;

  assign s_tready_w = (state == S_IDLE) && !r_tvalid;
  assign cmd_acc    = s_axis.tvalid && s_tready_w;
  assign tick       = (div_cnt == 16'(SCK_DIV - 1));
  // Half-periods are numbered 0..2N-1; the last one ends the frame.
  assign half_last  = (mode == MODE_REG) ? 16'(2*REG_BITS - 1) : 16'(2*CNV_N - 1);
  assign shift_end  = (state == S_SHIFT) && tick && sck_r && (half_cnt == half_last);
  assign enter_shift = (state != S_SHIFT) && (state_n == S_SHIFT);
  assign unused_cmd = ^s_axis.tdata;

  assign s_axis.tready     = s_tready_w;
  assign m_axis.tdata      = m_tdata;
  assign m_axis.tvalid     = m_tvalid;
  assign m_axis_reg.tdata  = r_tdata;
  assign m_axis_reg.tvalid = r_tvalid;
  assign spi_sdo    = sdo_r;
  assign spi_csn    = csn_r;
  assign spi_sck    = sck_r;
  assign spi_resetn = ~areset;
  assign overrun    = overrun_r;
  assign drop_count = drop_r;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        // A command beats a same-cycle trigger.
        if (cmd_acc)                              state_n = S_SHIFT;
        else if (trig_edge && mode == MODE_CNV)   state_n = (CNV_WAIT == 0) ? S_SHIFT : S_WAIT;
      end
      S_WAIT:  if (wait_cnt == 16'(CNV_WAIT - 1)) state_n = S_SHIFT;
      S_SHIFT: if (shift_end)                     state_n = S_GAP;
      S_GAP:   if (tick)                          state_n = S_IDLE;
      default:                                    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mode      <= MODE_CNV;
      stay      <= 1'b0;
      trig_q    <= 1'b0;
      trig_edge <= 1'b0;
      wait_cnt  <= '0;
      div_cnt   <= '0;
      half_cnt  <= '0;
      sck_r     <= 1'b0;
      csn_r     <= 1'b1;
      sdo_r     <= 1'b0;
      sdo_sr    <= '0;
      shreg     <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      overrun_r <= 1'b0;
      drop_r    <= '0;
    end else begin
      trig_q    <= trigger;
      trig_edge <= trigger & ~trig_q;

      if (m_axis.tready)     m_tvalid <= 1'b0;
      if (m_axis_reg.tready) r_tvalid <= 1'b0;

      // Edges that cannot start a conversion are errors, except while a
      // sticky register session deliberately masks triggers.
      if (trig_edge && !(state == S_IDLE && mode == MODE_CNV && !cmd_acc) &&
          !(mode == MODE_REG && stay))
        overrun_r <= 1'b1;

      if (cmd_acc) begin
        stay <= s_axis.tdata[31];
        mode <= MODE_REG;
      end

      if (enter_shift) begin
        csn_r    <= 1'b0;
        sck_r    <= 1'b0;
        div_cnt  <= '0;
        half_cnt <= '0;
        shreg    <= '0;
        // Conversions send nothing; sdo_sr stays zero so sdo idles low.
        sdo_r    <= cmd_acc ? s_axis.tdata[23] : 1'b0;
        sdo_sr   <= cmd_acc ? {s_axis.tdata[22:0], 1'b0} : 24'd0;
      end else begin
        case (state)
          S_IDLE: begin
            wait_cnt <= '0;
            div_cnt  <= '0;
          end
          S_WAIT: wait_cnt <= wait_cnt + 16'd1;
          S_SHIFT: begin
            if (tick) begin
              div_cnt  <= '0;
              half_cnt <= half_cnt + 16'd1;
              if (!sck_r) begin
                sck_r <= 1'b1;
                shreg <= (mode == MODE_REG) ? {shreg[DW-2:0], spi_sdi[0]}
                                            : {shreg[DW-NUM_SDI-1:0], spi_sdi};
              end else if (half_cnt == half_last) begin
                sck_r <= 1'b0;
                csn_r <= 1'b1;
                sdo_r <= 1'b0;
                if (mode == MODE_REG) begin
                  r_tdata  <= shreg;
                  r_tvalid <= 1'b1;
                  mode     <= stay ? MODE_REG : MODE_CNV;
                end else if (!m_tvalid || m_axis.tready) begin
                  m_tdata  <= shreg;
                  m_tvalid <= 1'b1;
                end else if (drop_r != 8'hFF) begin
                  drop_r <= drop_r + 8'd1;
                end
              end else begin
                sck_r  <= 1'b0;
                sdo_r  <= sdo_sr[23];
                sdo_sr <= {sdo_sr[22:0], 1'b0};
              end
            end else begin
              div_cnt <= div_cnt + 16'd1;
            end
          end
          S_GAP: div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_spi_adc_ctrl.sv
// Bench for axis_spi_adc_ctrl: an ADC model serves lane data per SCK rise,
// stimulus pushes expected words into queues, a monitor pops and compares
// on every output handshake.
`timescale 1ns/1ps
module tb_axis_spi_adc_ctrl;
  localparam int NUM_SDI = 4, CNV_BITS = 32, DW = 32, SCK_DIV = 2;
  localparam int CNV_WAIT = 8, REG_BITS = 24, N_CNV = CNV_BITS / NUM_SDI;

  logic aclk = 1'b0, areset = 1'b0, trigger = 1'b0;
  logic [NUM_SDI-1:0] spi_sdi = '0;
  logic spi_sdo, spi_csn, spi_sck, spi_resetn, overrun;
  logic [7:0] drop_count;

  axis_spi_adc_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
  axis_spi_adc_ctrl_if #(.DATA_WIDTH(DW)) m_if ();
  axis_spi_adc_ctrl_if #(.DATA_WIDTH(DW)) r_if ();

  axis_spi_adc_ctrl #(.NUM_SDI(NUM_SDI), .CNV_BITS(CNV_BITS), .DATA_WIDTH(DW),
    .SCK_DIV(SCK_DIV), .CNV_WAIT(CNV_WAIT), .REG_BITS(REG_BITS)) dut (
    .aclk(aclk), .areset(areset), .trigger(trigger), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_resetn(spi_resetn),
    .s_axis(s_if), .m_axis(m_if), .m_axis_reg(r_if),
    .overrun(overrun), .drop_count(drop_count));

  always #5 aclk = ~aclk;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC model: word presented lane-parallel, MSB nibble first; readback
  // pattern on lane 0 with junk on the other lanes.
  logic        tb_reg_mode = 1'b0;
  logic [31:0] adc_word = '0;
  logic [23:0] adc_reg = '0;
  int bit_idx = 0;
  function automatic logic [NUM_SDI-1:0] lane_val(input int idx);
    if (tb_reg_mode) begin
      if (idx < REG_BITS) return {3'b101, adc_reg[REG_BITS-1-idx]};
      return '0;
    end
    if (idx < N_CNV) return NUM_SDI'(adc_word >> (CNV_BITS - NUM_SDI*(idx+1)));
    return '0;
  endfunction
  always @(negedge spi_csn or posedge spi_sck) begin
    if (!spi_csn && spi_sck) bit_idx = bit_idx + 1;
    else bit_idx = 0;
    spi_sdi = lane_val(bit_idx);
  end

  // Frame observer.
  int frame_count = 0, rises = 0, last_rises = 0, last_len = 0;
  logic [23:0] sdo_bits = '0, last_sdo = '0;
  logic last_sdo_end = 1'b0;
  time t_fall = 0, t_trig = 0;
  always @(negedge spi_csn) begin t_fall = $time; rises = 0; sdo_bits = '0; end
  always @(posedge spi_sck) begin rises++; sdo_bits = {sdo_bits[22:0], spi_sdo}; end
  always @(posedge spi_csn) begin
    last_rises = rises;
    last_len = int'(($time - t_fall) / 10);
    last_sdo = sdo_bits;
    #1 last_sdo_end = spi_sdo;
    frame_count++;
  end

  // Scoreboard monitor.
  logic [31:0] exp_cnv[$], exp_reg[$];
  int cnv_beats = 0, reg_beats = 0;
  logic pv = 1'b0, phs = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge aclk) begin
    if (areset) pv = 1'b0;
    else begin
      if (pv && !phs && m_if.tvalid) chk("m_tdata_stable", m_if.tdata, pd);
      if (m_if.tvalid && m_if.tready) begin
        cnv_beats++;
        if (exp_cnv.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL m_beat: got unexpected word 0x%0h, expected none", m_if.tdata);
        end else chk("m_tdata", m_if.tdata, exp_cnv.pop_front());
      end
      if (r_if.tvalid && r_if.tready) begin
        reg_beats++;
        if (exp_reg.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL reg_beat: got unexpected word 0x%0h, expected none", r_if.tdata);
        end else chk("reg_tdata", r_if.tdata, exp_reg.pop_front());
      end
      pv = m_if.tvalid; pd = m_if.tdata; phs = m_if.tvalid && m_if.tready;
    end
  end

  logic rand_bp = 1'b0;
  always @(posedge aclk) if (rand_bp) begin
    #2;
    m_if.tready = ($urandom_range(0, 3) != 0);
    r_if.tready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(); @(posedge aclk); #2; endtask

  task automatic pulse_trigger();
    tick(); trigger = 1'b1;
    @(posedge aclk); t_trig = $time;
    #2 trigger = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frame_count < target && n < 2000) begin tick(); n++; end
    chk("frame_done", frame_count >= target, 1);
  endtask

  task automatic wait_csn_low();
    int n = 0;
    while (spi_csn && n < 200) begin tick(); n++; end
    chk("csn_low", spi_csn, 0);
  endtask

  task automatic send_cmd(input logic [31:0] w);
    int n = 0; bit acc = 0;
    tick(); s_if.tdata = w; s_if.tvalid = 1'b1;
    do begin @(negedge aclk); acc = s_if.tready; tick(); n++; end
    while (!acc && n < 2000);
    s_if.tvalid = 1'b0;
    chk("cmd_accepted", acc, 1);
  endtask

  task automatic run_conv(input logic [31:0] w, input bit push);
    int fc = frame_count;
    tb_reg_mode = 1'b0; adc_word = w;
    if (push) exp_cnv.push_back(w);
    pulse_trigger();
    wait_frames(fc + 1);
    chk("cnv_sck_rises", last_rises, N_CNV);
    chk("cnv_csn_low_len", last_len, 2*N_CNV*SCK_DIV);
    chk("cnv_latency", (t_fall - t_trig) / 10, 1 + CNV_WAIT);
    repeat (SCK_DIV + 3) tick();
  endtask

  task automatic run_reg(input logic [31:0] cmd, input logic [23:0] rb);
    int fc = frame_count;
    tb_reg_mode = 1'b1; adc_reg = rb;
    exp_reg.push_back({8'h00, rb});
    send_cmd(cmd);
    wait_frames(fc + 1);
    chk("reg_sck_rises", last_rises, REG_BITS);
    chk("reg_csn_low_len", last_len, 2*REG_BITS*SCK_DIV);
    chk("reg_sdo_bits", last_sdo, cmd[23:0]);
    chk("reg_sdo_idle", last_sdo_end, 0);
    repeat (SCK_DIV + 3) tick();
  endtask

  initial begin
    int fc, b0;
    logic [31:0] w;
    s_if.tvalid = 1'b0; s_if.tdata = '0;
    m_if.tready = 1'b1; r_if.tready = 1'b1;
    #1 areset = 1'b1;
    repeat (3) tick();
    chk("rst_csn", spi_csn, 1);        chk("rst_sck", spi_sck, 0);
    chk("rst_sdo", spi_sdo, 0);        chk("rst_resetn", spi_resetn, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0); chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_r_tvalid", r_if.tvalid, 0); chk("rst_r_tdata", r_if.tdata, 0);
    chk("rst_overrun", overrun, 0);    chk("rst_drop", drop_count, 0);
    areset = 1'b0;
    tick();
    chk("resetn_high", spi_resetn, 1);
    chk("s_tready_idle", s_if.tready, 1);

    // 1: nibbles 1..8
    run_conv(32'h12345678, 1);
    chk("t1_overrun", overrun, 0);

    // 2: register write with readback, then a conversion
    run_reg(32'h00801402, 24'hA5A5A5);
    run_conv($urandom, 1);

    // 3: sticky register mode masks triggers without overrun
    run_reg(32'h80000000, 24'($urandom));
    fc = frame_count;
    pulse_trigger();
    repeat (100) tick();
    chk("t3_no_frame", frame_count, fc);
    chk("t3_no_overrun", overrun, 0);
    run_reg(32'h00001400, 24'($urandom));
    run_conv($urandom, 1);
    chk("t3_overrun_after", overrun, 0);

    // 4: backpressure drops
    m_if.tready = 1'b0;
    w = $urandom;
    run_conv(w, 1);
    run_conv($urandom, 0);
    run_conv($urandom, 0);
    chk("t4_drop_count", drop_count, 2);
    chk("t4_tvalid_held", m_if.tvalid, 1);
    chk("t4_tdata_held", m_if.tdata, w);
    b0 = cnv_beats;
    m_if.tready = 1'b1;
    tick();
    chk("t4_tvalid_cleared", m_if.tvalid, 0);
    chk("t4_one_beat", cnv_beats, b0 + 1);

    // 5: retrigger during SHIFT
    fc = frame_count; b0 = cnv_beats;
    w = $urandom; tb_reg_mode = 1'b0; adc_word = w; exp_cnv.push_back(w);
    pulse_trigger();
    wait_csn_low();
    repeat (6) tick();
    pulse_trigger();
    tick();
    chk("t5_overrun", overrun, 1);
    wait_frames(fc + 1);
    repeat (20) tick();
    chk("t5_frames", frame_count, fc + 1);
    chk("t5_one_beat", cnv_beats, b0 + 1);

    // 6: reset mid-SHIFT
    b0 = cnv_beats;
    tb_reg_mode = 1'b0; adc_word = $urandom;
    pulse_trigger();
    wait_csn_low();
    repeat (5) tick();
    #1 areset = 1'b1;
    #1;
    chk("t6_csn", spi_csn, 1); chk("t6_sck", spi_sck, 0);
    chk("t6_resetn", spi_resetn, 0); chk("t6_tvalid", m_if.tvalid, 0);
    repeat (2) tick();
    areset = 1'b0;
    tick();
    chk("t6_overrun_cleared", overrun, 0);
    chk("t6_no_beat", cnv_beats, b0);
    run_conv($urandom, 1);

    // random traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) run_reg({8'h00, 24'($urandom)}, 24'($urandom));
      else run_conv($urandom, 1);
    end
    rand_bp = 1'b0;
    #3 m_if.tready = 1'b1; r_if.tready = 1'b1;
    repeat (20) tick();
    chk("end_cnv_queue", exp_cnv.size(), 0);
    chk("end_reg_queue", exp_reg.size(), 0);
    chk("end_drop", drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
